// File: rtl/sp_mc_pkg.sv
// Shared definitions for the sp_mc multi-cycle register-file processor:
// opcode and FSM encodings plus instruction field offset helpers.
package sp_mc_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_LDI  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    function automatic int op_msb(input int instr_w);
        return instr_w - 1;
    endfunction

    // rs (and the LDI destination) sits directly below the opcode.
    function automatic int rs_lsb(input int instr_w, input int reg_aw);
        return instr_w - 2 - reg_aw;
    endfunction

    function automatic int rt_lsb(input int instr_w, input int reg_aw);
        return instr_w - 2 - 2 * reg_aw;
    endfunction

endpackage

// File: rtl/sp_mc_seqmul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W steps.
// done and prod are presented combinationally during the final step.
module sp_mc_seqmul
    import sp_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   prod
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic                  running_q, running_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        running_d = running_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        if (running_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                done      = 1'b1;
                running_d = 1'b0;
            end
        end else if (start) begin
            mcand_d   = {{DATA_W{1'b0}}, a};
            mplier_d  = b;
            acc_d     = '0;
            cnt_d     = '0;
            running_d = 1'b1;
        end
        // Final accumulation is exposed so the caller can commit on the same edge.
        prod = acc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            running_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            running_q <= running_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/sp_mc.sv
// Multi-cycle register-file processor: ADD/LDI/READ complete in one cycle,
// MUL runs on the iterative multiplier and holds busy until it commits.
module sp_mc
    import sp_mc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREG    = 16,
    parameter int REG_AW  = $clog2(NREG),
    parameter int SAT     = 0,
    parameter int INSTR_W = 2 + REG_AW + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out,
    output logic               ovf
);
    localparam int OP_MSB = op_msb(INSTR_W);
    localparam int RS_LSB = rs_lsb(INSTR_W, REG_AW);
    localparam int RT_LSB = rt_lsb(INSTR_W, REG_AW);

    generate
        if (2 * REG_AW > DATA_W || NREG < 2 || (1 << REG_AW) != NREG) begin : g_param_check
            $error("sp_mc: illegal DATA_W/NREG combination");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [REG_AW-1:0]   mul_rd_q, mul_rd_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    op_e                 op;
    logic [REG_AW-1:0]   rs_addr, rt_addr, rd_addr;
    logic [DATA_W-1:0]   imm, rs_data, rt_data;
    logic [DATA_W:0]     sum;
    logic                wr_en;
    logic [REG_AW-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                mul_start, mul_done;
    logic [2*DATA_W-1:0] mul_prod;
    logic                mul_ovf;

    function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v, input logic o);
        return (SAT != 0 && o) ? {DATA_W{1'b1}} : v;
    endfunction

    assign op      = op_e'(instruction[OP_MSB -: 2]);
    assign rs_addr = instruction[RS_LSB +: REG_AW];
    assign rt_addr = instruction[RT_LSB +: REG_AW];
    assign rd_addr = instruction[REG_AW-1:0];
    assign imm     = instruction[DATA_W-1:0];
    assign rs_data = regs_q[rs_addr];
    assign rt_data = regs_q[rt_addr];
    assign sum     = {1'b0, rs_data} + {1'b0, rt_data};
    assign mul_ovf = |mul_prod[2*DATA_W-1:DATA_W];

    sp_mc_seqmul #(
        .DATA_W (DATA_W)
    ) u_seqmul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (rs_data),
        .b     (rt_data),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        mul_rd_d    = mul_rd_q;
        wr_en       = 1'b0;
        wr_addr     = rd_addr;
        wr_data     = '0;
        mul_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_ADD: begin
                            out_valid_d = 1'b1;
                            ovf_d       = sum[DATA_W];
                            out_d       = clamp(sum[DATA_W-1:0], sum[DATA_W]);
                            wr_en       = 1'b1;
                            wr_data     = clamp(sum[DATA_W-1:0], sum[DATA_W]);
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            mul_rd_d  = rd_addr;
                            state_d   = MUL;
                        end
                        OP_LDI: begin
                            // LDI reuses the rs field as its destination.
                            out_valid_d = 1'b1;
                            ovf_d       = 1'b0;
                            out_d       = imm;
                            wr_en       = 1'b1;
                            wr_addr     = rs_addr;
                            wr_data     = imm;
                        end
                        default: begin
                            out_valid_d = 1'b1;
                            ovf_d       = 1'b0;
                            out_d       = rs_data;
                        end
                    endcase
                end
            end
            default: begin
                if (mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    ovf_d       = mul_ovf;
                    out_d       = clamp(mul_prod[DATA_W-1:0], mul_ovf);
                    wr_en       = 1'b1;
                    wr_addr     = mul_rd_q;
                    wr_data     = clamp(mul_prod[DATA_W-1:0], mul_ovf);
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_next
        assign regs_d[gi] = (wr_en && wr_addr == REG_AW'(gi)) ? wr_data : regs_q[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mul_rd_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            mul_rd_q    <= mul_rd_d;
            regs_q      <= regs_d;
        end
    end

    assign busy      = (state_q == MUL);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sp_mc.sv
// Directed plus randomized bench for sp_mc; a wrapping and a saturating
// instance share stimulus and are checked against an arithmetic model.
module tb_sp_mc;
    localparam int DW = 8;
    localparam int NR = 16;
    localparam int IW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] instruction;
    logic          busy0, out_valid0, ovf0;
    logic          busy1, out_valid1, ovf1;
    logic [DW-1:0] out0, out1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [2][NR];
    logic [7:0] exp_out [2];
    logic       exp_ovf [2];

    always #5 clk = ~clk;

    sp_mc #(.DATA_W(DW), .NREG(NR), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .busy(busy0), .out_valid(out_valid0), .out(out0), .ovf(ovf0));

    sp_mc #(.DATA_W(DW), .NREG(NR), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .busy(busy1), .out_valid(out_valid1), .out(out1), .ovf(ovf1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy);
        check({tag, " sat0 out_valid"}, 32'(out_valid0), 32'd0);
        check({tag, " sat1 out_valid"}, 32'(out_valid1), 32'd0);
        check({tag, " sat0 busy"}, 32'(busy0), 32'(exp_busy));
        check({tag, " sat1 busy"}, 32'(busy1), 32'(exp_busy));
    endtask

    task automatic check_done(input string tag);
        check({tag, " sat0 out_valid"}, 32'(out_valid0), 32'd1);
        check({tag, " sat1 out_valid"}, 32'(out_valid1), 32'd1);
        check({tag, " sat0 busy"}, 32'(busy0), 32'd0);
        check({tag, " sat1 busy"}, 32'(busy1), 32'd0);
        check({tag, " sat0 out"}, 32'(out0), 32'(exp_out[0]));
        check({tag, " sat1 out"}, 32'(out1), 32'(exp_out[1]));
        check({tag, " sat0 ovf"}, 32'(ovf0), 32'(exp_ovf[0]));
        check({tag, " sat1 ovf"}, 32'(ovf1), 32'(exp_ovf[1]));
        $display("%s: out=%0d/%0d ovf=%0b/%0b", tag, out0, out1, ovf0, ovf1);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model_exec(input logic [1:0] op, input logic [3:0] f1, input logic [3:0] f2,
                              input logic [3:0] f3, input logic [7:0] imm);
        for (int s = 0; s < 2; s++) begin
            int unsigned a, b, r;
            a = mdl[s][f1];
            b = mdl[s][f2];
            case (op)
                2'b00:   r = a + b;
                2'b01:   r = a * b;
                2'b10:   r = imm;
                default: r = a;
            endcase
            exp_ovf[s] = (op == 2'b00 || op == 2'b01) && (r > 255);
            exp_out[s] = (exp_ovf[s] && s == 1) ? 8'hFF : 8'(r % 256);
            if (op == 2'b10) mdl[s][f1] = imm;
            else if (op != 2'b11) mdl[s][f3] = exp_out[s];
        end
    endtask

    function automatic logic [IW-1:0] enc(input logic [1:0] op, input logic [3:0] f1,
                                          input logic [3:0] f2, input logic [3:0] f3,
                                          input logic [7:0] imm);
        if (op == 2'b10) return {op, f1, imm};
        return {op, f1, f2, f3};
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [3:0] f1, input logic [3:0] f2,
                         input logic [3:0] f3, input logic [7:0] imm, input string tag);
        model_exec(op, f1, f2, f3, imm);
        instruction = enc(op, f1, f2, f3, imm);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (op == 2'b01) begin
            check_quiet({tag, " accept"}, 1'b1);
            for (int i = 1; i < DW; i++) begin
                tick();
                check_quiet({tag, " wait"}, 1'b1);
            end
            tick();
        end
        check_done(tag);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < NR; r++) mdl[s][r] = 8'd0;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        instruction = '0;
        model_reset();
        tick();
        tick();
        check_quiet("reset", 1'b0);
        check("reset sat0 out", 32'(out0), 32'd0);
        check("reset sat0 ovf", 32'(ovf0), 32'd0);
        rst = 1'b1;

        // 1: read of a cleared register
        do_op(2'b11, 4'd5, 4'd0, 4'd0, 8'd0, "t1 read r5");
        check("t1 out literal", 32'(out0), 32'd0);

        // 2: ADD overflow, wrap vs saturate
        do_op(2'b10, 4'd1, 4'd0, 4'd0, 8'd200, "t2 ldi r1");
        do_op(2'b10, 4'd2, 4'd0, 4'd0, 8'd100, "t2 ldi r2");
        do_op(2'b00, 4'd1, 4'd2, 4'd3, 8'd0, "t2 add r3");
        check("t2 wrap literal", 32'(out0), 32'd44);
        check("t2 sat literal", 32'(out1), 32'd255);
        do_op(2'b11, 4'd3, 4'd0, 4'd0, 8'd0, "t2 read r3");

        // 3: MUL without and with overflow
        do_op(2'b10, 4'd4, 4'd0, 4'd0, 8'd13, "t3 ldi r4");
        do_op(2'b10, 4'd5, 4'd0, 4'd0, 8'd11, "t3 ldi r5");
        do_op(2'b01, 4'd4, 4'd5, 4'd6, 8'd0, "t3 mul 13x11");
        check("t3 mul literal", 32'(out0), 32'd143);
        do_op(2'b10, 4'd7, 4'd0, 4'd0, 8'd20, "t3 ldi r7");
        do_op(2'b01, 4'd7, 4'd7, 4'd8, 8'd0, "t3 mul 20x20");
        check("t3 mul wrap literal", 32'(out0), 32'd144);
        check("t3 mul sat literal", 32'(out1), 32'd255);

        // 4: ADD held on the input during a MUL is dropped until busy falls
        model_exec(2'b01, 4'd4, 4'd5, 4'd6, 8'd0);
        instruction = enc(2'b01, 4'd4, 4'd5, 4'd6, 8'd0);
        in_valid = 1'b1;
        tick();
        instruction = enc(2'b00, 4'd4, 4'd5, 4'd4, 8'd0);
        check_quiet("t4 accept", 1'b1);
        for (int i = 1; i < DW; i++) begin
            tick();
            check_quiet("t4 held add", 1'b1);
        end
        tick();
        check_done("t4 mul done");
        model_exec(2'b00, 4'd4, 4'd5, 4'd4, 8'd0);
        tick();
        in_valid = 1'b0;
        check_done("t4 add after busy");
        tick();
        check_quiet("t4 idle", 1'b0);

        // 5: reset during the 4th MUL cycle aborts it
        instruction = enc(2'b01, 4'd4, 4'd5, 4'd9, 8'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        check_quiet("t5 after reset", 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_quiet("t5 no late pulse", 1'b0);
        end
        for (int r = 0; r < NR; r++)
            do_op(2'b11, 4'(r), 4'd0, 4'd0, 8'd0, $sformatf("t5 read r%0d", r));

        // 6: back-to-back dependent ADDs
        do_op(2'b10, 4'd0, 4'd0, 4'd0, 8'd1, "t6 ldi r0");
        for (int i = 0; i < 4; i++) begin
            do_op(2'b00, 4'd0, 4'd0, 4'd0, 8'd0, $sformatf("t6 add #%0d", i));
            check("t6 doubling", 32'(out0), 32'(2 << i));
        end

        // Random traffic
        for (int r = 0; r < NR; r++)
            do_op(2'b10, 4'(r), 4'd0, 4'd0, 8'($urandom_range(0, 255)), $sformatf("rnd ldi r%0d", r));
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            do_op(op, 4'($urandom_range(0, NR - 1)), 4'($urandom_range(0, NR - 1)),
                  4'($urandom_range(0, NR - 1)), 8'($urandom_range(0, 255)),
                  $sformatf("rnd %0d op%0d", n, op));
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check_quiet("rnd gap", 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
